// File: rtl/sort_pkg.sv
// sort_pkg: shared FSM state encoding, counter-width helper and lane pad constant
// for the streaming sort controller.
package sort_pkg;
  typedef enum logic [1:0] {LOAD, SORT, DRAIN} sort_state_e;
  localparam int PAD_MAX_W = 256;
  localparam logic [PAD_MAX_W-1:0] PAD_ALL = '1;
  function automatic int calc_cw(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/parallel_sorter.sv
// parallel_sorter: combinational odd-even transposition sort of N unsigned lanes;
// flattened lane 0 in the LSBs, output lane 0 holds the minimum.
module parallel_sorter #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic [N*DW-1:0] inp,
  output logic [N*DW-1:0] outp
);
  logic [DW-1:0] v [N];
  logic [DW-1:0] t;
  always_comb begin
    t = '0;
    outp = '0;
    for (int i = 0; i < N; i++) v[i] = inp[i*DW +: DW];
    for (int s = 0; s < N; s++)
      for (int i = s % 2; i + 1 < N; i += 2) begin
        t = v[i];
        v[i] = (t > v[i+1]) ? v[i+1] : t;
        v[i+1] = (t > v[i+1]) ? t : v[i+1];
      end
    for (int i = 0; i < N; i++) outp[i*DW +: DW] = v[i];
  end
endmodule

// File: rtl/sort_stream_ctrl.sv
// sort_stream_ctrl: loads up to N words from a valid/ready stream, sorts them in
// one cycle and drains the sorted batch smallest first, marking the last word.
module sort_stream_ctrl
  import sort_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);
  localparam int CW = calc_cw(N);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [DW-1:0] W_PAD = PAD_ALL[DW-1:0];

  sort_state_e     r_state, w_next;
  logic [DW-1:0]   r_buf [N];
  logic [DW-1:0]   r_res [N];
  logic [CW-1:0]   r_cnt, r_len, r_idx;
  logic [N*DW-1:0] w_flat, w_sorted;
  logic            w_in_hs, w_out_hs, w_load_done, w_last;

  assign in_ready    = r_state == LOAD;
  assign out_valid   = r_state == DRAIN;
  assign busy        = r_state != LOAD;
  assign w_in_hs     = in_valid && in_ready;
  assign w_out_hs    = out_valid && out_ready;
  assign w_load_done = w_in_hs && (r_cnt == CW'(N - 1) || in_last);
  assign w_last      = r_idx == r_len - 1'b1;
  assign out_last    = out_valid && w_last;
  assign out_data    = out_valid ? r_res[r_idx[IW-1:0]] : '0;

  always_comb begin
    w_flat = '0;
    for (int i = 0; i < N; i++) w_flat[i*DW +: DW] = r_buf[i];
  end

  parallel_sorter #(.N(N), .DW(DW)) u_sorter (
    .inp  (w_flat),
    .outp (w_sorted)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD:    w_next = w_load_done ? SORT : LOAD;
      SORT:    w_next = DRAIN;
      DRAIN:   w_next = (w_out_hs && w_last) ? LOAD : DRAIN;
      default: w_next = LOAD;
    endcase
  end

  // Unwritten lanes keep the all-ones pad so they sort past batch_len and are never read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD;
      r_cnt   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      for (int i = 0; i < N; i++) begin
        r_buf[i] <= W_PAD;
        r_res[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      if (w_in_hs) begin
        r_buf[r_cnt[IW-1:0]] <= in_data;
        r_cnt <= w_load_done ? '0 : r_cnt + 1'b1;
        if (w_load_done) r_len <= r_cnt + 1'b1;
      end
      if (r_state == SORT) begin
        r_idx <= '0;
        for (int i = 0; i < N; i++) r_res[i] <= w_sorted[i*DW +: DW];
      end
      if (w_out_hs) begin
        r_idx <= r_idx + 1'b1;
        if (w_last)
          for (int i = 0; i < N; i++) r_buf[i] <= W_PAD;
      end
    end
  end
endmodule

// File: tb/tb_sort_stream_ctrl.sv
// tb_sort_stream_ctrl: directed batches with hand-computed sorted results pushed
// to a scoreboard; a negedge monitor pops and compares each accepted output word.
module tb_sort_stream_ctrl;
  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          in_valid = 0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 0;
  logic          out_valid;
  logic          out_ready = 1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_hs = 0;
  int first_valid = 0;
  logic [DW:0] exp_q [$];

  logic          prev_stall = 0;
  logic          prev_valid = 0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 0;

  sort_stream_ctrl #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    bit hs = 0;
    in_valid = 1;
    in_data  = d;
    in_last  = l;
    for (int k = 0; k < 100 && !hs; k++) begin
      @(negedge clk);
      hs = in_ready;
      if (hs) last_hs = cyc;
      @(posedge clk);
      #1;
    end
    if (!hs) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout data=%0d never accepted", d);
    end
  endtask

  task automatic idle();
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain_timeout_left", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall && out_valid) begin
        chk("stall_hold_data", out_data, prev_data);
        chk("stall_hold_last", out_last, prev_last);
      end
      if (out_valid) chk("in_ready_while_drain", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out got=%0d exp=none", out_data);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          chk("out_data", out_data, e[DW-1:0]);
          chk("out_last", out_last, e[DW]);
        end
      end
      if (out_valid && !prev_valid) first_valid = cyc;
      prev_stall = out_valid && !out_ready;
      prev_valid = out_valid;
      prev_data  = out_data;
      prev_last  = out_last;
    end else begin
      prev_stall = 0;
      prev_valid = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic pat [4];
    bit seen;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // full batch with latency and SORT-cycle checks
    push(1, 0); push(3, 0); push(7, 0); push(9, 1);
    send(9, 0); send(3, 0); send(7, 0); send(1, 0);
    idle();
    @(negedge clk);
    chk("sort_in_ready", in_ready, 0);
    chk("sort_busy", busy, 1);
    chk("sort_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    wait_drain();
    chk("latency", first_valid - last_hs, 2);

    // partial batch: pads must never be emitted
    push(5, 0); push(200, 1);
    send(200, 0); send(5, 1);
    idle();
    wait_drain();
    @(negedge clk);
    chk("partial_in_ready_back", in_ready, 1);
    chk("partial_out_valid_off", out_valid, 0);
    @(posedge clk);
    #1;

    // genuine all-ones data and ties
    push(0, 0); push(0, 0); push(255, 0); push(255, 1);
    send(255, 0); send(0, 0); send(255, 0); send(0, 0);
    idle();
    wait_drain();

    // backpressure during drain
    out_ready = 0;
    push(2, 0); push(4, 0); push(6, 0); push(8, 1);
    send(4, 0); send(2, 0); send(8, 0); send(6, 0);
    idle();
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk);
      #1;
      seen = out_valid;
    end
    chk("bp_out_valid_seen", seen, 1);
    for (int i = 0; i < 4; i++) begin
      out_ready = pat[i];
      @(posedge clk);
      #1;
    end
    out_ready = 1;
    wait_drain();

    // reset after the second output word
    push(10, 0); push(20, 0);
    send(40, 0); send(30, 0); send(20, 0); send(10, 0);
    idle();
    wait_drain();
    rst_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_data", out_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    push(1, 0); push(2, 0); push(3, 0); push(4, 1);
    send(4, 0); send(3, 0); send(2, 0); send(1, 0);
    idle();
    wait_drain();

    // input held while busy is taken only as the next batch's first word
    push(11, 0); push(12, 1); push(50, 0); push(77, 1);
    send(11, 0); send(12, 1);
    send(77, 0); send(50, 1);
    idle();
    wait_drain();
    repeat (3) @(negedge clk);
    chk("final_idle_out_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sort_stream_ctrl.md
Name: sort_stream_ctrl

Overview:
Sequencing controller that wraps the combinational parallel_sorter so it can sit on a word-serial valid/ready stream. It collects up to N words into a load buffer and presents them to the sorter in parallel. It registers the sorted vector and streams it back out, smallest first, one word per accepted beat. An early in_last closes a partial batch; unused lanes are padded so they sort to the end and are never emitted.

Parameters:
N, 4, number of sort lanes; must be ≥2; passed through to parallel_sorter.
DW, 8, word width in bits; passed through to parallel_sorter.
CW, $clog2(N+1), width of the internal word counter (localparam, not overridable).

Ports:
clk  in  1  single clock; all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  input word valid.
in_ready  out  1  controller can accept an input word.
in_data  in  DW  input word, unsigned.
in_last  in  1  final word of batch; qualified by in_valid&&in_ready.
out_valid  out  1  sorted word valid.
out_ready  in  1  downstream accepts the sorted word.
out_data  out  DW  sorted word, unsigned.
out_last  out  1  marks the final sorted word of the batch.
busy  out  1  high in SORT or DRAIN.

Behaviour:
- Reset (async assert, sync-released use): state=LOAD, counter=0, load buffer = all-ones per lane, result register = 0, out_valid=0, out_last=0, out_data=0, busy=0. in_ready=1 once rst_n is high.
- States: LOAD, SORT, DRAIN.
- LOAD:
  - in_ready=1. Each handshake writes in_data to lane[count] and increments count.
  - Transition to SORT when the handshake has count==N-1 or in_last=1. Store batch_len = count+1.
  - Lanes not written keep all-ones padding, so they sort to the top lanes.
  - No transition occurs without a handshake, so a zero-length batch is impossible.
- SORT:
  - Exactly one cycle. in_ready=0.
  - Sorter output is captured into the result register, lane 0 holding the minimum and lane N-1 the maximum.
  - Read index is cleared to 0. Next state is DRAIN.
- DRAIN:
  - out_valid=1 and out_data=result[idx], driven from registers with no combinational path from the inputs.
  - out_last=1 when idx==batch_len-1.
  - On out_valid&&out_ready: idx increments. If out_last was high, go to LOAD: counter=0, load buffer re-filled with all-ones, out_valid=0 next cycle.
  - While out_ready=0, out_data and out_last stay stable.
- Latency: the first output word is valid 2 cycles after the last input handshake edge (1 SORT cycle + the DRAIN register).
- Throughput: N words in, 1 bubble cycle, N words out. There is no overlap between loading and draining: in_ready=0 throughout SORT and DRAIN.
- Ties: equal values are emitted in any order. Genuine all-ones data words are legal; only batch_len words are emitted, so a pad is never output.
- Reset mid-operation: any partial batch or pending drain is discarded and the controller returns to the reset values immediately.
- in_last while count==N-1: behaves as a full batch; the two conditions do not conflict.
- in_valid is ignored outside LOAD. Data presented then is not consumed and must be held by the upstream.

Decomposition:
- Shared package sort_pkg holds:
  - state enum sort_state_e {LOAD, SORT, DRAIN};
  - localparam function for CW;
  - the pad constant (all-ones of DW).
- Sub-module: the existing parallel_sorter, instantiated once with N and DW, fed the flattened load buffer. Its outp is flattened lane-0-in-LSBs.
- No other sub-module; counter and FSM live in sort_stream_ctrl.

Test Plan:
1. Full batch, N=4, DW=8: input 9,3,7,1 with out_ready=1 -> output 1,3,7,9 with out_last on 9; first out_valid 2 cycles after the 4th handshake; in_ready=0 until 9 is accepted.
2. Partial batch: input 200,5 with in_last on 5 -> output 5,200 with out_last on 200; no pad word emitted; in_ready returns next cycle.
3. All-ones and ties: input 255,0,255,0 -> output 0,0,255,255; out_last on the 4th word, count correct.
4. Backpressure: out_ready toggles 1,0,0,1 during drain of 4,2,8,6 -> out_data holds stable while stalled; sequence 2,4,6,8 is delivered with no drop or duplicate.
5. Reset mid-drain: assert rst_n=0 after the 2nd output word -> out_valid=0 asynchronously, in_ready=1 after release; the next batch 4,3,2,1 gives 1,2,3,4 with no stale data.
6. Input while busy: hold in_valid=1 with data 77 during SORT/DRAIN -> not accepted; 77 is loaded as the first word of the next batch.
